// File: rtl/divu_hilo.sv
// divu_hilo: sequential 32-cycle restoring unsigned divider with Hi (remainder) / Lo (quotient) read-back.
// Optional sticky divide-by-zero flag output enabled by defining DIVU_ZERO_FLAG_EN.
module divu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
`ifdef DIVU_ZERO_FLAG_EN
    output logic             divZero,
`endif
    output logic             busy
);
    localparam logic [5:0] F_DIVU = 6'd27;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, hi_q, lo_q, dout_q;
    logic [5:0]       sig_q;
    logic             busy_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic             start;

    // The remainder never reaches the top bit before the final step, so
    // shifting it together with the quotient MSB is an exact WIDTH+1 trial.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign start = (state_q == IDLE) && (Signal == F_DIVU) && (sig_q != F_DIVU);

    assign dataOut = dout_q;
    assign busy    = busy_q;

`ifdef DIVU_ZERO_FLAG_EN
    logic dz_q;
    assign divZero = dz_q;
    always_ff @(posedge clk) begin
        if (!reset)
            dz_q <= 1'b0;
        else if (start)
            dz_q <= (dataB == '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dout_q  <= '0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            sig_q  <= Signal;
            dout_q <= (Signal == F_MFHI) ? hi_q : (Signal == F_MFLO) ? lo_q : '0;
            if (state_q == IDLE) begin
                if (start) begin
                    rem_q   <= '0;
                    quo_q   <= dataA;
                    dvs_q   <= dataB;
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
            end else begin
                rem_q   <= rem_d;
                quo_q   <= quo_d;
                count_q <= count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    hi_q    <= rem_d;
                    lo_q    <= quo_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            end
        end
    end
endmodule

// File: doc/divu_hilo.md
# divu_hilo

Sequential 32-bit unsigned divider with its own Hi/Lo result registers, the divide-side counterpart of the ALU's 32-cycle multiplier. It accepts the same function-code bus as the ALU: code 27 (DIVU) starts a division, and codes 16 (MFHI) and 18 (MFLO) read the results back. The quotient goes to Lo and the remainder to Hi, following MIPS DIVU semantics. It sits beside the ALU and shares the dataA/dataB operand buses and the Signal bus.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- clk  input  1  single system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising clk edge
- dataA  input  WIDTH  dividend, sampled on start edge
- dataB  input  WIDTH  divisor, sampled on start edge
- Signal  input  6  function code: 27 DIVU, 16 MFHI, 18 MFLO, others ignored
- dataOut  output  WIDTH  registered read-back data
- busy  output  1  high while division in progress
- divZero  output  1  only with DIVU_ZERO_FLAG_EN; sticky divide-by-zero flag

## Operation
- States: IDLE, RUN.
- Start condition: state IDLE, Signal==27, and the registered previous Signal!=27 (rising-edge detect).
  - Holding 27 for many cycles starts exactly one division.
- On the start edge:
  - rem=0, quo=dataA, dvs=dataB, count=0, state goes to RUN.
- Each RUN edge performs one restoring step:
  - {rem,quo} shifted left 1.
  - trial = {1'b0,rem_shifted} - {1'b0,dvs} (WIDTH+1 bits).
  - If trial is non-negative: rem=trial[WIDTH-1:0] and quo LSB=1; else quo LSB=0.
  - count increments.
- On the WIDTH-th RUN edge: Hi=final rem, Lo=final quo, state goes to IDLE.
- Divide by zero runs the normal iteration with no special path:
  - Lo=all ones (0xFFFFFFFF).
  - Hi=dividend.
- Signal==27 while in RUN is ignored; the operation is neither aborted nor restarted.
- dataA/dataB changes after the start edge have no effect.
- Read-back, registered every edge:
  - Signal==16 gives dataOut=Hi.
  - Signal==18 gives dataOut=Lo.
  - Any other code gives dataOut=0.
  - MFHI/MFLO during RUN return the previous Hi/Lo; they never expose partial rem/quo.
- Reset low on any edge, including mid-RUN:
  - State goes to IDLE, count=0, Hi=0, Lo=0, dataOut=0, busy=0, previous-Signal register=0, divZero=0.
  - Any in-flight result is discarded.

## Timing
- Edge numbering: start edge = edge 0; RUN steps at edges 1..32.
- Hi/Lo are written at edge 32; busy falls at edge 32.
- First edge that can return the new result on dataOut: edge 33, with Signal=16/18 applied before it.
- busy rises at edge 0 and stays high for edges 0..31.
- Latency from start edge to Hi/Lo valid: 32 cycles.
  - Matches the multiplier window, so a bench that waits 33 cycles and then issues MFHI/MFLO works unchanged.
- dataOut read latency: 1 edge after Signal is presented.
- Back-to-back division: a new start is accepted at edge 33 at the earliest.
  - Signal must leave 27 for at least one edge first, for the edge detector.
- Reset values of all outputs are 0.

## Configuration
- DIVU_ZERO_FLAG_EN defined:
  - Adds the divZero output.
  - divZero is set on a start edge with dataB==0 and held until the next start edge with dataB!=0, or until reset.
  - Division timing and results are unchanged.
- DIVU_ZERO_FLAG_EN undefined: no divZero port or logic; divide-by-zero results are still as specified above.

## Test plan
- Basic: reset low 1 cycle; DIVU 100/7; wait 33 cycles -> MFHI dataOut=2, MFLO dataOut=14; busy high exactly 32 cycles.
- Extremes:
  - 0xFFFFFFFF/1 -> Hi=0, Lo=0xFFFFFFFF.
  - 5/10 -> Hi=5, Lo=0.
  - 0x80000000/0xFFFFFFFF -> Hi=0x80000000, Lo=0.
- Divide by zero: 1234/0 -> Hi=1234, Lo=0xFFFFFFFF.
  - With DIVU_ZERO_FLAG_EN: divZero=1 from edge 0.
  - divZero clears on the next start of 9/3, which gives Lo=3, Hi=0.
- Hold and busy reads:
  - Signal held at 27 for 40 cycles -> only one busy pulse.
  - MFLO during RUN of a second division returns the first division's Lo.
  - Changing dataA mid-RUN does not alter the result.
- Reset mid-operation: reset low at RUN edge 10 -> busy=0, MFHI/MFLO=0.
  - A subsequent DIVU 50/8 gives Hi=2, Lo=6.
- Randomized: 1000 random pairs with dataB!=0, checked against the reference model a/b and a%b.
